// File: rtl/raycast_pkg.sv
// Shared raycaster constants: screen geometry, col_data field
// slices, palette defaults and the column painter state encoding.
package raycast_pkg;

  localparam int SCREEN_WIDTH_DEF  = 320;
  localparam int SCREEN_HEIGHT_DEF = 180;

  localparam logic [7:0] CEIL_COLOR_DEF  = 8'h01;
  localparam logic [7:0] FLOOR_COLOR_DEF = 8'h02;

  localparam int COL_W   = 22;
  localparam int HC_MSB  = 21;
  localparam int HC_LSB  = 13;
  localparam int LH_MSB  = 12;
  localparam int LH_LSB  = 5;
  localparam int WT_BIT  = 4;
  localparam int MAP_MSB = 3;
  localparam int MAP_LSB = 0;

  localparam int HC_W  = HC_MSB - HC_LSB + 1;
  localparam int LH_W  = LH_MSB - LH_LSB + 1;
  localparam int MAP_W = MAP_MSB - MAP_LSB + 1;

  typedef enum logic [1:0] {
    IDLE,
    PAINT,
    DONE
  } painter_state_e;

  // Bit 4 picks the darker palette bank for Y-side wall hits.
  function automatic logic [7:0] wall_color(
    input logic             wt,
    input logic [MAP_W-1:0] map
  );
    return {3'b001, wt, map};
  endfunction

endpackage

// File: rtl/column_span_calc.sv
// Vertical wall span of one column from its projected line height:
// combinational limits for the load cycle, registered copies after.
module column_span_calc
  import raycast_pkg::*;
#(
  parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter int SW            = $clog2(SCREEN_HEIGHT + 1)
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            load_in,
  input  logic [LH_W-1:0] line_height_in,
  output logic [SW-1:0]   start_c_out,
  output logic [SW-1:0]   end_c_out,
  output logic [SW-1:0]   start_out,
  output logic [SW-1:0]   end_out
);

  logic [15:0]   lh_w;
  logic [15:0]   h_w;
  logic [15:0]   lh_c;
  logic [15:0]   s_w;
  logic [15:0]   e_w;
  logic [SW-1:0] start_d, start_q;
  logic [SW-1:0] end_d, end_q;

  always_comb begin
    lh_w        = 16'(line_height_in);
    h_w         = 16'(SCREEN_HEIGHT);
    lh_c        = (lh_w > h_w) ? h_w : lh_w;
    s_w         = (h_w - lh_c) >> 1;
    e_w         = s_w + lh_c;
    start_c_out = SW'(s_w);
    end_c_out   = SW'(e_w);
  end

  always_comb begin
    start_d = start_q;
    end_d   = end_q;
    if (load_in) begin
      start_d = start_c_out;
      end_d   = end_c_out;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      start_q <= '0;
      end_q   <= '0;
    end else begin
      start_q <= start_d;
      end_q   <= end_d;
    end
  end

  assign start_out = start_q;
  assign end_out   = end_q;

endmodule

// File: rtl/dda_column_painter.sv
// Paints one ray result per column into the framebuffer, one pixel per
// accepted write. Define SHADE_Y_WALL_EN to shade Y-side wall hits.
module dda_column_painter
  import raycast_pkg::*;
#(
  parameter int         SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int         SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter logic [7:0] CEIL_COLOR    = CEIL_COLOR_DEF,
  parameter logic [7:0] FLOOR_COLOR   = FLOOR_COLOR_DEF,
  localparam int        AW = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
  input  logic             pixel_clk_in,
  input  logic             rst_in,
  input  logic [COL_W-1:0] col_data_in,
  input  logic             col_valid_in,
  output logic             col_ready_out,
  input  logic             fb_ready_in,
  output logic [AW-1:0]    fb_addr_out,
  output logic [7:0]       fb_data_out,
  output logic             fb_we_out,
  output logic             fb_sel_out,
  output logic             column_done_out,
  output logic             frame_done_out,
  output logic             busy_out
);

  localparam int SW = $clog2(SCREEN_HEIGHT + 1);

  painter_state_e state_d, state_q;

  logic [HC_W-1:0] hcount_d, hcount_q;
  logic [7:0]      wall_d, wall_q;
  logic [SW-1:0]   vcount_d, vcount_q;
  logic [AW-1:0]   addr_d, addr_q;
  logic [7:0]      data_d, data_q;
  logic            we_d, we_q;
  logic            ready_d, ready_q;
  logic            busy_d, busy_q;
  logic            cdone_d, cdone_q;
  logic            fdone_d, fdone_q;
  logic            sel_d, sel_q;

  logic [HC_W-1:0]  hc_in;
  logic [LH_W-1:0]  lh_in;
  logic             wt_in;
  logic [MAP_W-1:0] map_in;
  logic [7:0]       wall_in;
  logic             accept;
  logic             wr_ok;
  logic [SW-1:0]    span_start_c, span_end_c;
  logic [SW-1:0]    span_start_q, span_end_q;

  assign hc_in  = col_data_in[HC_MSB:HC_LSB];
  assign lh_in  = col_data_in[LH_MSB:LH_LSB];
  assign wt_in  = col_data_in[WT_BIT];
  assign map_in = col_data_in[MAP_MSB:MAP_LSB];

`ifdef SHADE_Y_WALL_EN
  assign wall_in = wall_color(wt_in, map_in);
`else
  logic unused_wt;
  assign unused_wt = wt_in;
  assign wall_in   = wall_color(1'b0, map_in);
`endif

  assign accept = col_valid_in && ready_q;
  assign wr_ok  = we_q && fb_ready_in;

  column_span_calc #(
    .SCREEN_HEIGHT(SCREEN_HEIGHT),
    .SW           (SW)
  ) u_span (
    .clk_in        (pixel_clk_in),
    .rst_in        (rst_in),
    .load_in       (accept),
    .line_height_in(lh_in),
    .start_c_out   (span_start_c),
    .end_c_out     (span_end_c),
    .start_out     (span_start_q),
    .end_out       (span_end_q)
  );

  function automatic logic [7:0] pick_color(
    input logic [SW-1:0] v,
    input logic [SW-1:0] ds,
    input logic [SW-1:0] de,
    input logic [7:0]    wall
  );
    if (v < ds) return CEIL_COLOR;
    if (v < de) return wall;
    return FLOOR_COLOR;
  endfunction

  always_comb begin
    state_d  = state_q;
    hcount_d = hcount_q;
    wall_d   = wall_q;
    vcount_d = vcount_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = we_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    sel_d    = sel_q;
    cdone_d  = 1'b0;
    fdone_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          ready_d  = 1'b0;
          hcount_d = hc_in;
          wall_d   = wall_in;
          vcount_d = '0;
          if (int'(hc_in) < SCREEN_WIDTH) begin
            state_d = PAINT;
            busy_d  = 1'b1;
            we_d    = 1'b1;
            addr_d  = AW'(hc_in);
            data_d  = pick_color('0, span_start_c,
                                 span_end_c, wall_in);
          end else begin
            // Off-screen column: report it done without painting.
            state_d = DONE;
            cdone_d = 1'b1;
          end
        end
      end
      PAINT: begin
        if (wr_ok) begin
          if (int'(vcount_q) == SCREEN_HEIGHT - 1) begin
            state_d = DONE;
            we_d    = 1'b0;
            busy_d  = 1'b0;
            cdone_d = 1'b1;
            if (int'(hcount_q) == SCREEN_WIDTH - 1) begin
              fdone_d = 1'b1;
              sel_d   = ~sel_q;
            end
          end else begin
            vcount_d = vcount_q + SW'(1);
            addr_d   = addr_q + AW'(SCREEN_WIDTH);
            data_d   = pick_color(vcount_q + SW'(1),
                                  span_start_q, span_end_q,
                                  wall_q);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      hcount_q <= '0;
      wall_q   <= '0;
      vcount_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      cdone_q  <= 1'b0;
      fdone_q  <= 1'b0;
      sel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcount_q <= hcount_d;
      wall_q   <= wall_d;
      vcount_q <= vcount_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      cdone_q  <= cdone_d;
      fdone_q  <= fdone_d;
      sel_q    <= sel_d;
    end
  end

  assign col_ready_out   = ready_q;
  assign fb_addr_out     = addr_q;
  assign fb_data_out     = data_q;
  assign fb_we_out       = we_q;
  assign fb_sel_out      = sel_q;
  assign column_done_out = cdone_q;
  assign frame_done_out  = fdone_q;
  assign busy_out        = busy_q;

endmodule

// File: tb/tb_dda_column_painter.sv
// Directed bench for dda_column_painter: expected pixel writes are
// queued per column and popped as the framebuffer accepts them.
module tb_dda_column_painter;

  localparam int W = 320;
  localparam int H = 180;

  logic        clk = 1'b0;
  logic        rst_in;
  logic [21:0] col_data_in;
  logic        col_valid_in;
  logic        col_ready_out;
  logic        fb_ready_in;
  logic [15:0] fb_addr_out;
  logic [7:0]  fb_data_out;
  logic        fb_we_out;
  logic        fb_sel_out;
  logic        column_done_out;
  logic        frame_done_out;
  logic        busy_out;

  always #5 clk = ~clk;

  dda_column_painter dut (
    .pixel_clk_in   (clk),
    .rst_in         (rst_in),
    .col_data_in    (col_data_in),
    .col_valid_in   (col_valid_in),
    .col_ready_out  (col_ready_out),
    .fb_ready_in    (fb_ready_in),
    .fb_addr_out    (fb_addr_out),
    .fb_data_out    (fb_data_out),
    .fb_we_out      (fb_we_out),
    .fb_sel_out     (fb_sel_out),
    .column_done_out(column_done_out),
    .frame_done_out (frame_done_out),
    .busy_out       (busy_out)
  );

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_q[$];

  int ncmp, nfail;
  int n_wr, n_cd, n_fd, n_wall, n_ceil, n_floor, cyc;
  int acc_cyc;
  bit have_acc, stream_on, rand_on;
  logic [7:0]  last_wall;
  logic        prev_stall;
  logic [15:0] p_addr;
  logic [7:0]  p_data;
  logic [7:0]  exp_shade;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_px(input int v, input int lh,
                                          input bit wt,
                                          input logic [3:0] map);
    int l;
    int ds;
    int de;
    logic [7:0] wall;
    l = (lh > H) ? H : lh;
    ds = (H - l) / 2;
    de = ds + l;
`ifdef SHADE_Y_WALL_EN
    wall = {3'b001, wt, map};
`else
    wall = {3'b001, 1'b0, map};
`endif
    if (v < ds) return 8'h01;
    if (v < de) return wall;
    return 8'h02;
  endfunction

  task automatic push_col(input logic [8:0] hc, input int lh,
                          input bit wt, input logic [3:0] map);
    wr_t e;
    if (int'(hc) < W) begin
      for (int v = 0; v < H; v++) begin
        e.a = 16'(int'(hc) + v * W);
        e.d = model_px(v, lh, wt, map);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send(input logic [8:0] hc, input int lh, input bit wt,
                      input logic [3:0] map, input bit keep);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (col_ready_out) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ready_wait", 32'(ok), 32'd1);
    col_data_in  = {hc, 8'(lh), wt, map};
    col_valid_in = 1'b1;
    push_col(hc, lh, wt, map);
    if (stream_on && have_acc)
      chk("spacing", 32'(cyc - acc_cyc), 32'(H + 2));
    acc_cyc  = cyc;
    have_acc = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) col_valid_in = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c0;
    c0 = n_cd;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (rand_on) fb_ready_in = 1'($urandom_range(0, 1));
      if (n_cd > c0) break;
    end
    fb_ready_in = 1'b1;
    chk("col_done_wait", 32'(n_cd - c0), 32'd1);
  endtask

  initial begin
    int w0, cd0, fd0, ce0, wa0, fl0;
`ifdef SHADE_Y_WALL_EN
    exp_shade = 8'h33;
`else
    exp_shade = 8'h23;
`endif
    ncmp = 0; nfail = 0; n_wr = 0; n_cd = 0; n_fd = 0;
    n_wall = 0; n_ceil = 0; n_floor = 0; cyc = 0;
    have_acc = 0; stream_on = 0; rand_on = 0;
    prev_stall = 0; p_addr = '0; p_data = '0; last_wall = '0;
    rst_in = 1; col_valid_in = 0; col_data_in = '0; fb_ready_in = 1;

    fork
      forever begin
        wr_t e;
        @(negedge clk);
        cyc++;
        if (fb_we_out && fb_ready_in) begin
          n_wr++;
          if (exp_q.size() == 0) begin
            chk("unexpected_write", {16'd0, fb_addr_out}, 32'hffff_ffff);
          end else begin
            e = exp_q.pop_front();
            chk("addr", 32'(fb_addr_out), 32'(e.a));
            chk("data", 32'(fb_data_out), 32'(e.d));
          end
          if (fb_data_out == 8'h01) n_ceil++;
          else if (fb_data_out == 8'h02) n_floor++;
          else begin
            n_wall++;
            last_wall = fb_data_out;
          end
        end
        if (prev_stall && fb_we_out) begin
          chk("stall_addr", 32'(fb_addr_out), 32'(p_addr));
          chk("stall_data", 32'(fb_data_out), 32'(p_data));
        end
        prev_stall = fb_we_out && !fb_ready_in;
        p_addr = fb_addr_out;
        p_data = fb_data_out;
        if (column_done_out) n_cd++;
        if (frame_done_out) begin
          n_fd++;
          chk("fd_with_cd", 32'(column_done_out), 32'd1);
        end
      end
    join_none

    // Reset state and ready latency
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", 32'(fb_we_out), 0);
    chk("rst_ready", 32'(col_ready_out), 0);
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_sel", 32'(fb_sel_out), 0);
    chk("rst_cd", 32'(column_done_out), 0);
    chk("rst_fd", 32'(frame_done_out), 0);
    chk("rst_addr", 32'(fb_addr_out), 0);
    chk("rst_data", 32'(fb_data_out), 0);
    @(posedge clk);
    #1 rst_in = 0;
    @(negedge clk);
    chk("ready_lag", 32'(col_ready_out), 0);
    @(negedge clk);
    chk("ready_up", 32'(col_ready_out), 1);

    // Basic column
    w0 = n_wr; cd0 = n_cd; ce0 = n_ceil; wa0 = n_wall; fl0 = n_floor;
    send(9'd5, 60, 1'b0, 4'd3, 1'b0);
    wait_done(2000);
    repeat (3) @(posedge clk);
    chk("c5_writes", 32'(n_wr - w0), 180);
    chk("c5_ceil", 32'(n_ceil - ce0), 60);
    chk("c5_wall", 32'(n_wall - wa0), 60);
    chk("c5_floor", 32'(n_floor - fl0), 60);
    chk("c5_wallval", 32'(last_wall), 32'h23);
    chk("c5_cd_once", 32'(n_cd - cd0), 1);

    // lineHeight = 0
    w0 = n_wr; ce0 = n_ceil; wa0 = n_wall; fl0 = n_floor;
    send(9'd7, 0, 1'b0, 4'd6, 1'b0);
    wait_done(2000);
    chk("lh0_ceil", 32'(n_ceil - ce0), 90);
    chk("lh0_wall", 32'(n_wall - wa0), 0);
    chk("lh0_floor", 32'(n_floor - fl0), 90);

    // lineHeight saturates
    ce0 = n_ceil; wa0 = n_wall; fl0 = n_floor;
    send(9'd10, 255, 1'b0, 4'd7, 1'b0);
    wait_done(2000);
    chk("lh255_ceil", 32'(n_ceil - ce0), 0);
    chk("lh255_wall", 32'(n_wall - wa0), 180);
    chk("lh255_floor", 32'(n_floor - fl0), 0);

    // Y-wall shading
    send(9'd20, 60, 1'b1, 4'd3, 1'b0);
    wait_done(2000);
    chk("shade_val", 32'(last_wall), 32'(exp_shade));

    // Random framebuffer back-pressure
    w0 = n_wr;
    rand_on = 1;
    send(9'd33, 100, 1'b0, 4'd9, 1'b0);
    wait_done(4000);
    rand_on = 0;
    chk("stall_writes", 32'(n_wr - w0), 180);

    // Off-screen column
    w0 = n_wr; fd0 = n_fd;
    send(9'd400, 60, 1'b0, 4'd1, 1'b0);
    wait_done(100);
    chk("drop_writes", 32'(n_wr - w0), 0);
    chk("drop_fd", 32'(n_fd - fd0), 0);

    // Reset mid-column at row 100
    w0 = n_wr;
    send(9'd50, 60, 1'b0, 4'd4, 1'b0);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (fb_we_out && fb_addr_out == 16'(50 + 100 * W)) break;
    end
    fb_ready_in = 0;
    rst_in = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_we", 32'(fb_we_out), 0);
    chk("rst_mid_writes", 32'(n_wr - w0), 100);
    chk("rst_mid_left", 32'(exp_q.size()), 80);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_in = 0;
    fb_ready_in = 1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_ready", 32'(col_ready_out), 1);
    chk("rst_mid_nowr", 32'(n_wr - w0), 100);
    w0 = n_wr;
    send(9'd60, 60, 1'b0, 4'd5, 1'b0);
    wait_done(2000);
    chk("after_rst_writes", 32'(n_wr - w0), 180);

    // Full frame streamed back-to-back
    chk("sel_before", 32'(fb_sel_out), 0);
    w0 = n_wr; fd0 = n_fd;
    stream_on = 1;
    have_acc = 0;
    for (int c = 0; c < W; c++) begin
      if (c == W - 1) chk("fd_early", 32'(n_fd - fd0), 0);
      send(9'(c), 60, 1'b0, 4'(c), 1'b1);
    end
    col_valid_in = 0;
    wait_done(2000);
    stream_on = 0;
    repeat (3) @(posedge clk);
    chk("frame_fd", 32'(n_fd - fd0), 1);
    chk("frame_sel", 32'(fb_sel_out), 1);
    chk("frame_writes", 32'(n_wr - w0), 32'(W * H));
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
